// File: rtl/net_eval_seq_pkg.sv
// net_eval_seq shared types: sequencer states, mode codes, float constants.
package net_eval_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_START,
    S_WAIT,
    S_CHECK,
    S_NEXT,
    S_FINISH
  } state_t;

  localparam logic [1:0] M_XOR = 2'd0;
  localparam logic [1:0] M_AND = 2'd1;
  localparam logic [1:0] M_OR  = 2'd2;
  localparam logic [1:0] M_MAN = 2'd3;

  localparam logic [31:0] F_ONE  = 32'h3f80_0000;
  localparam logic [31:0] F_ZERO = 32'h0000_0000;
  localparam logic [31:0] F_HALF = 32'h3f00_0000;

endpackage

// File: rtl/net_eval_seq_float_gt.sv
// Combinational y > THRESH for IEEE-754 single with a positive threshold.
module net_eval_seq_float_gt
  import net_eval_seq_pkg::*;
#(
  parameter logic [31:0] THRESH = F_HALF
) (
  input  logic [31:0] y,
  output logic        gt
);

  logic nan;

  assign nan = (y[30:23] == 8'hff) && (y[22:0] != 23'd0);
  // Positive floats order like their magnitude bits.
  assign gt  = !nan && !y[31] && (y[30:0] > THRESH[30:0]);

endmodule

// File: rtl/net_eval_seq.sv
// Self-test sequencer: walks input vectors through the net handshake,
// thresholds outputs and tallies pass/fail with a per-vector timeout.
module net_eval_seq
  import net_eval_seq_pkg::*;
#(
  parameter int          I       = 2,
  parameter int          O       = 1,
  parameter int          TIMEOUT = 1024,
  parameter logic [31:0] ONE     = F_ONE,
  parameter logic [31:0] THRESH  = F_HALF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            go,
  input  logic [1:0]      mode,
  input  logic [I-1:0]    sw_vec,
  output logic            net_rst_n,
  output logic            net_start,
  output logic [32*I-1:0] net_x,
  input  logic [32*O-1:0] net_y,
  input  logic            net_done,
  output logic            busy,
  output logic            done,
  output logic [I:0]      pass_cnt,
  output logic [I:0]      fail_cnt,
  output logic            timeout_flag,
  output logic            all_pass,
  output logic [O-1:0]    result
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
  localparam logic [I-1:0] LAST = '1;

  state_t        state, state_n;
  logic [1:0]    mode_q;
  logic [I-1:0]  idx, vec_q;
  logic [TW-1:0] tcnt;
  logic          tmo;
  logic [O-1:0]  res_c;
  logic          exp_b, last, ok;

  assign last      = (mode_q == M_MAN) || (idx == LAST);
  assign net_rst_n = !rst && (state != S_CLEAR);
  assign net_start = (state == S_START);
  assign done      = (state == S_FINISH);
  assign busy      = (state != S_IDLE) && (state != S_FINISH);
  assign all_pass  = done && (fail_cnt == '0);

  for (genvar k = 0; k < O; k++) begin : g_gt
    net_eval_seq_float_gt #(.THRESH(THRESH)) u_gt (
      .y  (net_y[32*k +: 32]),
      .gt (res_c[k])
    );
  end

  for (genvar j = 0; j < I; j++) begin : g_x
    assign net_x[32*j +: 32] = vec_q[j] ? ONE : F_ZERO;
  end

  always_comb begin
    exp_b = ^vec_q;
    unique case (mode_q)
      M_XOR: exp_b = ^vec_q;
      M_AND: exp_b = &vec_q;
      M_OR:  exp_b = |vec_q;
      M_MAN: exp_b = ^vec_q;
    endcase
  end

  assign ok = !tmo && (res_c == {O{exp_b}});

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE, S_FINISH:
        if (go) state_n = S_CLEAR;
      S_CLEAR: state_n = S_START;
      S_START: state_n = S_WAIT;
      S_WAIT:
        if (net_done || tcnt == TLAST)
          state_n = S_CHECK;
      S_CHECK: state_n = S_NEXT;
      S_NEXT:
        state_n = last ? S_FINISH : S_CLEAR;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      mode_q       <= M_XOR;
      idx          <= '0;
      vec_q        <= '0;
      tcnt         <= '0;
      tmo          <= 1'b0;
      pass_cnt     <= '0;
      fail_cnt     <= '0;
      timeout_flag <= 1'b0;
      result       <= '0;
    end else begin
      state <= state_n;
      unique case (state)
        S_IDLE, S_FINISH:
          if (go) begin
            mode_q       <= mode;
            idx          <= '0;
            vec_q        <= (mode == M_MAN) ? sw_vec : '0;
            pass_cnt     <= '0;
            fail_cnt     <= '0;
            timeout_flag <= 1'b0;
          end
        S_START: begin
          tcnt <= '0;
          tmo  <= 1'b0;
        end
        S_WAIT:
          if (!net_done) begin
            if (tcnt == TLAST) begin
              tmo          <= 1'b1;
              timeout_flag <= 1'b1;
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
        S_CHECK: begin
          result <= res_c;
          if (ok) pass_cnt <= pass_cnt + 1'b1;
          else    fail_cnt <= fail_cnt + 1'b1;
        end
        S_NEXT:
          if (!last) begin
            idx   <= idx + 1'b1;
            vec_q <= idx + 1'b1;
          end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_net_eval_seq.sv
// Bench for net_eval_seq: stub net plus run-level reference model.
module tb_net_eval_seq;

  localparam int I = 2;
  localparam int O = 1;
  localparam int TIMEOUT = 1024;
  localparam logic [31:0] ONE = 32'h3f80_0000;

  logic            clk = 0;
  logic            rst, go;
  logic [1:0]      mode;
  logic [I-1:0]    sw_vec;
  logic            net_rst_n, net_start;
  logic [32*I-1:0] net_x;
  logic [32*O-1:0] net_y;
  logic            net_done;
  logic            busy, done;
  logic [I:0]      pass_cnt, fail_cnt;
  logic            timeout_flag, all_pass;
  logic [O-1:0]    result;

  net_eval_seq #(.I(I), .O(O), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .go(go), .mode(mode), .sw_vec(sw_vec),
    .net_rst_n(net_rst_n), .net_start(net_start), .net_x(net_x),
    .net_y(net_y), .net_done(net_done), .busy(busy), .done(done),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .timeout_flag(timeout_flag), .all_pass(all_pass), .result(result)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Stub net: done level 'dly' cycles after start (0 = never),
  // y = 1.0 on odd input parity, or a programmed word per vector.
  int          dly = 5;
  bit          ym = 0;
  logic [31:0] yrand [8];
  int          scnt = 0;
  int          sc = 0;

  always @(posedge clk) begin
    if (!net_rst_n) scnt <= 0;
    else if (net_start) scnt <= 1;
    else if (scnt != 0) scnt <= scnt + 1;
    if (go && !busy) sc <= 0;
    else if (net_start) sc <= sc + 1;
  end

  assign net_done = (dly != 0) && (scnt != 0) && (scnt >= dly);

  always_comb begin
    int par;
    par = 0;
    for (int j = 0; j < I; j++)
      if (net_x[32*j +: 32] == ONE) par = par ^ 1;
    net_y = ym ? yrand[sc & 7] : (par != 0 ? ONE : 32'h0);
  end

  // Reference float: decode to a real and compare numerically.
  function automatic bit gt_half(input logic [31:0] y);
    int  e;
    real m, mag;
    e = int'(y[30:23]);
    m = real'(y[22:0]);
    if (e == 255) return (m == 0.0) && !y[31];
    if (e == 0) mag = m * (2.0 ** (-149));
    else mag = (1.0 + m / 8388608.0) * (2.0 ** (e - 127));
    return (y[31] ? -mag : mag) > 0.5;
  endfunction

  int              m_len, m_pass, m_fail, m_cyc;
  bit              m_tmo, m_res, m_active = 0;
  logic [32*I-1:0] exq[$];

  task automatic build(input logic [1:0] md, input logic [I-1:0] sw);
    int nv;
    m_len = 0; m_pass = 0; m_fail = 0; m_tmo = 0; m_res = 0;
    exq.delete();
    nv = (md == 3) ? 1 : (1 << I);
    for (int n = 0; n < nv; n++) begin
      int v, ones, w;
      bit to, r, e;
      logic [31:0] y;
      logic [32*I-1:0] x;
      v = (md == 3) ? int'(sw) : n;
      ones = $countones(v);
      to = (dly == 0) || (dly > TIMEOUT);
      w = to ? TIMEOUT : dly;
      y = ym ? yrand[n + 1] : ((ones % 2) != 0 ? ONE : 32'h0);
      r = gt_half(y);
      case (md)
        2'd0: e = (ones % 2) != 0;
        2'd1: e = (v == (1 << I) - 1);
        2'd2: e = (v != 0);
        default: e = (ones % 2) != 0;
      endcase
      if (!to && r == e) m_pass++; else m_fail++;
      if (to) m_tmo = 1;
      m_res = r;
      m_len += 4 + w;
      x = '0;
      for (int j = 0; j < I; j++)
        if (((v >> j) & 1) != 0) x[32*j +: 32] = ONE;
      exq.push_back(x);
    end
  endtask

  always @(negedge clk) begin
    if (m_active) begin
      if (net_start) begin
        if (exq.size() == 0) chk("extra_start", 1, 0);
        else chk("net_x", net_x, exq.pop_front());
      end
      chk("busy", busy, m_cyc < m_len);
      chk("done", done, m_cyc >= m_len);
      if (m_cyc >= m_len) begin
        chk("pass_cnt", pass_cnt, m_pass);
        chk("fail_cnt", fail_cnt, m_fail);
        chk("timeout_flag", timeout_flag, m_tmo);
        chk("result", result, m_res);
        chk("all_pass", all_pass, m_fail == 0);
      end
    end
  end

  task automatic run(input logic [1:0] md, input logic [I-1:0] sw,
                     input bit glitch, output int lat);
    build(md, sw);
    @(posedge clk); #1;
    mode = md; sw_vec = sw; go = 1;
    @(posedge clk); #1;
    go = 0; lat = 0; m_cyc = 0; m_active = 1;
    while (done !== 1'b1 && lat < m_len + 20) begin
      go = glitch && (lat == 3);
      @(posedge clk); #1;
      lat++; m_cyc = lat;
    end
    go = 0;
    if (done !== 1'b1) chk("done_bound", 0, 1);
    @(negedge clk); #1;
    m_active = 0;
    chk("latency", lat, m_len);
    chk("all_started", exq.size(), 0);
  endtask

  function automatic logic [31:0] pick_y();
    case ($urandom_range(5))
      0: return 32'h3f00_0000;
      1: return 32'h3f00_0001;
      2: return 32'h8000_0000;
      3: return 32'h7fc0_0000;
      4: return ONE;
      default: return $urandom;
    endcase
  endfunction

  logic [31:0] bval [4];
  bit          bexp [4];
  int lat;

  initial begin
    rst = 1; go = 0; mode = 0; sw_vec = 0;
    for (int k = 0; k < 8; k++) yrand[k] = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_net_rst_n", net_rst_n, 0);
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass_cnt, 0);
    chk("rst_fail", fail_cnt, 0);
    chk("rst_tmo", timeout_flag, 0);
    chk("rst_start", net_start, 0);
    chk("rst_x", net_x, 0);
    chk("rst_result", result, 0);
    chk("idle_net_rst_n", net_rst_n, 1);

    dly = 5; ym = 0;
    run(2'd0, 2'b00, 0, lat);
    chk("xor_lat36", lat, 36);
    chk("xor_pass4", pass_cnt, 4);
    chk("xor_allpass", all_pass, 1);

    run(2'd1, 2'b00, 0, lat);
    chk("and_pass1", pass_cnt, 1);
    chk("and_fail3", fail_cnt, 3);
    chk("and_allpass0", all_pass, 0);

    dly = 0;
    run(2'd2, 2'b00, 0, lat);
    chk("tmo_lat", lat, 4 * (TIMEOUT + 4));
    chk("tmo_fail4", fail_cnt, 4);
    chk("tmo_flag", timeout_flag, 1);

    dly = TIMEOUT;
    run(2'd0, 2'b00, 0, lat);
    chk("edge_done_wins", pass_cnt, 4);
    chk("edge_no_tmo", timeout_flag, 0);

    dly = 5;
    run(2'd3, 2'b10, 0, lat);
    chk("man_x", net_x, 64'h3f800000_00000000);
    chk("man_pass1", pass_cnt, 1);
    chk("man_done", done, 1);

    bval = '{32'h3f00_0000, 32'h3f00_0001, 32'h8000_0000, 32'h7fc0_0000};
    bexp = '{0, 1, 0, 0};
    ym = 1; dly = 3;
    for (int b = 0; b < 4; b++) begin
      yrand[1] = bval[b];
      run(2'd3, 2'b01, 0, lat);
      chk($sformatf("bound_res_%0h", bval[b]), result, bexp[b]);
    end

    ym = 0; dly = 6;
    run(2'd2, 2'b00, 1, lat);
    chk("glitch_or_pass3", pass_cnt, 3);

    for (int t = 0; t < 14; t++) begin
      ym = $urandom_range(1);
      dly = $urandom_range(40, 1);
      for (int k = 0; k < 8; k++) yrand[k] = pick_y();
      run(2'($urandom_range(3)), I'($urandom), 0, lat);
    end

    ym = 0; dly = 5;
    build(2'd0, 2'b00);
    @(posedge clk); #1;
    mode = 2'd0; go = 1;
    @(posedge clk); #1;
    go = 0; lat = 0; m_cyc = 0; m_active = 1;
    while (lat < 21) begin
      @(posedge clk); #1;
      lat++; m_cyc = lat;
    end
    m_active = 0;
    chk("pre_rst_pass2", pass_cnt, 2);
    rst = 1;
    @(negedge clk);
    chk("mid_rst_net_rst_n", net_rst_n, 0);
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_pass", pass_cnt, 0);
    chk("abort_fail", fail_cnt, 0);
    chk("abort_x", net_x, 0);
    chk("abort_net_rst_n", net_rst_n, 1);
    exq.delete();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
